leg4_core: RTL and testbench
============================

# leg4_core

Four-bit TD4-style execution core that sits directly downstream of the program ROM. Each cycle it drives the program counter onto `rom_addr`, latches the returned 8-bit instruction, executes it against registers A/B, the carry flag, the input port and the output port, then advances or loads the PC. It is paced by an external `step` enable, so the same core runs at full clock rate or from a slow board tick.

## Interface
- No parameters. Widths are fixed by the 4-bit ISA.
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `step`  in  1  advance enable; FSM moves only on cycles where `step`=1
- `rom_addr`  out  4  instruction address (= PC)
- `rom_data`  in  8  instruction from ROM, combinational on `rom_addr`
- `in_port`  in  4  external input, sampled in EXEC by IN instructions
- `out_port`  out  4  registered output port
- `reg_a`  out  4  register A (debug)
- `reg_b`  out  4  register B (debug)
- `carry`  out  1  carry flag (debug)
- `instr_done`  out  1  one-cycle pulse when an instruction retires

## Operation
- Instruction word: `op`=`rom_data[7:4]`, `im`=`rom_data[3:0]`.
- FSM has two states, FETCH and EXEC; it is a transition-only machine gated by `step`.
  - FETCH: `rom_addr`=PC. On `step`, IR <= `rom_data`; go to EXEC.
  - EXEC: on `step`, execute IR and update PC; pulse `instr_done`; go to FETCH.
- Opcodes (executed in EXEC); PC <= PC+1 unless stated otherwise:
  - 0000 ADD A,im: {C,A} <= A+im
  - 0101 ADD B,im: {C,B} <= B+im
  - 0011 MOV A,im: A <= im
  - 0111 MOV B,im: B <= im
  - 0001 MOV A,B: A <= B
  - 0100 MOV B,A: B <= A
  - 0010 IN A: A <= `in_port`
  - 0110 IN B: B <= `in_port`
  - 1001 OUT B: `out_port` <= B
  - 1011 OUT im: `out_port` <= im
  - 1111 JMP im: PC <= im
  - 1110 JNC im: PC <= im if C==0, else PC+1
  - 1000, 1010, 1100, 1101: NOP, PC+1.
- Carry rule: C is written by every executed instruction.
  - ADD sets C to the 5th sum bit.
  - All other opcodes, including JNC and NOP, clear C.
  - JNC tests the C value from before the instruction.
- Arithmetic is 4-bit modulo 16. PC+1 wraps from 15 to 0.
- `out_port` holds its value until the next OUT instruction.

## Timing
- Reset values: PC=0, A=0, B=0, C=0, IR=0, `out_port`=0, `instr_done`=0, state=FETCH. Therefore `rom_addr`=0.
- `rst` wins over `step` in the same cycle.
- Reset in EXEC abandons the pending instruction: no register, port or flag update, and no `instr_done`.
- With `step` held at 1, one instruction retires every 2 clocks.
- `instr_done` is high in the cycle after the EXEC edge, for exactly one clock.
- Register, PC and `out_port` updates are all visible in that same cycle as `instr_done`.
- `step`=0 freezes all state. `instr_done` is 0 in any cycle not immediately following an EXEC step.
- `rom_data` is only sampled in FETCH on a `step` edge. `in_port` is only sampled in EXEC on a `step` edge.
- `rom_addr` changes only after an EXEC edge. It is stable throughout FETCH.

## Test plan
- Reset/stall:
  - Assert `rst` with `step`=1 → all outputs 0, `rom_addr`=0.
  - Hold `step`=0 for 10 cycles after reset → no output changes, `instr_done` never high.
- ADD carry:
  - Program: MOV A,9 (0x39); ADD A,8 (0x08).
  - Required: A=1, C=1 after the 2nd `instr_done`.
  - Next instruction MOV B,3 (0x73) → B=3, C=0.
- JNC both paths, `in_port`=4:
  - Program: 0x20 IN A; 0x08 ADD A,8; 0xE8 JNC 8.
  - Required: A=12, C=0, jump taken, PC=8.
  - Rerun with `in_port`=9 → A=1, C=1, jump not taken, PC=3.
- OUT sequence:
  - Program at 3..7: 0xB1, 0xB2, 0xB4, 0xB8, 0xF0.
  - Required: `out_port` steps 1,2,4,8 on successive `instr_done` pulses, then PC=0.
- PC wrap and NOP:
  - ROM filled with 0x80.
  - Required: PC runs 0..15 then 0, with 16 `instr_done` pulses per lap; A, B, C, `out_port` stay 0.
- Mid-instruction reset:
  - Assert `rst` while in EXEC of 0xB5.
  - Required: `out_port` stays 0, no `instr_done`, next fetch from address 0.

Source files
------------

// File: rtl/leg4_core.sv
// leg4_core: four-bit TD4-style core with a step-paced two-state fetch/execute machine
module leg4_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic [3:0] in_port,
    output logic [3:0] out_port,
    output logic [3:0] reg_a,
    output logic [3:0] reg_b,
    output logic       carry,
    output logic       instr_done
);
    typedef enum logic {FETCH, EXEC} state_t;
    state_t     state;
    logic [3:0] pc;
    logic [7:0] ir;
    logic [3:0] op, im, a_nxt, b_nxt, out_nxt, pc_nxt;
    logic [4:0] sum;
    logic       c_nxt;
    assign rom_addr = pc;
    // Decode the latched instruction into next-state values for the EXEC step
    always_comb begin
        op      = ir[7:4];
        im      = ir[3:0];
        sum     = (op == 4'b0101 ? {1'b0, reg_b} : {1'b0, reg_a}) + {1'b0, im};
        a_nxt   = op == 4'b0000 ? sum[3:0] : op == 4'b0011 ? im : op == 4'b0001 ? reg_b : op == 4'b0010 ? in_port : reg_a;
        b_nxt   = op == 4'b0101 ? sum[3:0] : op == 4'b0111 ? im : op == 4'b0100 ? reg_a : op == 4'b0110 ? in_port : reg_b;
        c_nxt   = (op == 4'b0000 || op == 4'b0101) ? sum[4] : 1'b0;
        out_nxt = op == 4'b1001 ? reg_b : op == 4'b1011 ? im : out_port;
        pc_nxt  = (op == 4'b1111 || (op == 4'b1110 && !carry)) ? im : pc + 4'd1;
    end
    // Fetch latches the ROM word; execute commits all architectural state at once
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= '0;
            ir         <= '0;
            reg_a      <= '0;
            reg_b      <= '0;
            carry      <= 1'b0;
            out_port   <= '0;
            instr_done <= 1'b0;
        end else begin
            instr_done <= 1'b0;
            if (step) begin
                if (state == FETCH) begin
                    ir    <= rom_data;
                    state <= EXEC;
                end else begin
                    reg_a      <= a_nxt;
                    reg_b      <= b_nxt;
                    carry      <= c_nxt;
                    out_port   <= out_nxt;
                    pc         <= pc_nxt;
                    instr_done <= 1'b1;
                    state      <= FETCH;
                end
            end
        end
    end
endmodule

// File: tb/tb_leg4_core.sv
// tb_leg4_core: randomized and directed checks of leg4_core against an ISA-level model
module tb_leg4_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step = 1'b0;
    logic [3:0] rom_addr, in_port = '0, out_port, reg_a, reg_b;
    logic [7:0] rom_data;
    logic       carry, instr_done;
    logic [7:0] rom [16];
    int         n_tests = 0, n_fail = 0;
    bit         m_exec;
    logic [7:0] m_ir;
    int         m_pc, m_a, m_b, m_c, m_out, m_done;

    leg4_core dut (
        .clk(clk), .rst(rst), .step(step), .rom_addr(rom_addr), .rom_data(rom_data),
        .in_port(in_port), .out_port(out_port), .reg_a(reg_a), .reg_b(reg_b),
        .carry(carry), .instr_done(instr_done)
    );

    assign rom_data = rom[rom_addr];
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run_instr(input logic [7:0] w);
        int o, i, s, oldc;
        o = w[7:4];
        i = w[3:0];
        oldc = m_c;
        m_c = 0;
        m_pc = (m_pc + 1) % 16;
        case (o)
            0:  begin s = m_a + i; m_a = s % 16; m_c = s / 16; end
            5:  begin s = m_b + i; m_b = s % 16; m_c = s / 16; end
            3:  m_a = i;
            7:  m_b = i;
            1:  m_a = m_b;
            4:  m_b = m_a;
            2:  m_a = in_port;
            6:  m_b = in_port;
            9:  m_out = m_b;
            11: m_out = i;
            15: m_pc = i;
            14: if (oldc == 0) m_pc = i;
            default: ;
        endcase
    endtask

    task automatic tick(input logic r, input logic s);
        rst = r;
        step = s;
        @(posedge clk);
        m_done = 0;
        if (r) begin
            m_exec = 0; m_ir = '0; m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;
        end else if (s) begin
            if (!m_exec) m_ir = rom[m_pc];
            else begin
                run_instr(m_ir);
                m_done = 1;
            end
            m_exec = !m_exec;
        end
        #1;
        check("rom_addr", rom_addr, m_pc);
        check("reg_a", reg_a, m_a);
        check("reg_b", reg_b, m_b);
        check("carry", carry, m_c);
        check("out_port", out_port, m_out);
        check("instr_done", instr_done, m_done);
    endtask

    task automatic retire(input int n);
        int got = 0;
        for (int i = 0; i < 4 * n && got < n; i++) begin
            tick(1'b0, 1'b1);
            if (instr_done) got++;
        end
        check("retire_cnt", got, n);
    endtask

    task automatic fill(input logic [7:0] w);
        for (int i = 0; i < 16; i++) rom[i] = w;
    endtask

    initial begin
        fill(8'h80);
        tick(1'b1, 1'b1);
        check("rst_addr", rom_addr, 0);
        check("rst_out", out_port, 0);
        check("rst_done", instr_done, 0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        check("stall_addr", rom_addr, 0);

        rom[0] = 8'h39; rom[1] = 8'h08; rom[2] = 8'h73;
        tick(1'b1, 1'b0);
        retire(2);
        check("add_a", reg_a, 1);
        check("add_c", carry, 1);
        retire(1);
        check("movb_b", reg_b, 3);
        check("movb_c", carry, 0);

        fill(8'h80);
        rom[0] = 8'h20; rom[1] = 8'h08; rom[2] = 8'hE8;
        in_port = 4'd4;
        tick(1'b1, 1'b0);
        retire(3);
        check("jnc_t_a", reg_a, 12);
        check("jnc_t_c", carry, 0);
        check("jnc_t_pc", rom_addr, 8);
        in_port = 4'd9;
        tick(1'b1, 1'b0);
        retire(2);
        check("jnc_n_a", reg_a, 1);
        check("jnc_n_c", carry, 1);
        retire(1);
        check("jnc_n_pc", rom_addr, 3);
        check("jnc_n_c2", carry, 0);

        fill(8'h80);
        rom[3] = 8'hB1; rom[4] = 8'hB2; rom[5] = 8'hB4; rom[6] = 8'hB8; rom[7] = 8'hF0;
        tick(1'b1, 1'b0);
        retire(3);
        for (int k = 0; k < 4; k++) begin
            retire(1);
            check("out_seq", out_port, 1 << k);
        end
        retire(1);
        check("out_jmp_pc", rom_addr, 0);

        fill(8'h80);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            retire(1);
            check("wrap_pc", rom_addr, (i + 1) % 16);
        end
        check("wrap_out", out_port, 0);
        check("wrap_a", reg_a, 0);

        rom[0] = 8'hB5;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        check("midrst_out", out_port, 0);
        check("midrst_done", instr_done, 0);
        tick(1'b0, 1'b0);
        check("midrst_done2", instr_done, 0);
        retire(1);
        check("midrst_refetch", out_port, 5);

        tick(1'b1, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0)
                for (int j = 0; j < 16; j++) rom[j] = 8'($urandom);
            in_port = 4'($urandom);
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
